kong_ctrl: RTL and testbench
============================

Name: kong_ctrl

Overview:
- Sequences the Kong character's position and animation for the game screen.
- Runs the intro: from the initial animation point, Kong climbs vertically to platform height, then walks left onto his platform.
- Once on the platform, serves barrel-throw and jump requests from game logic, one at a time.
- Drives xpos/ypos/frame into the Kong sprite draw block, and pulses barrel_spawn to the barrel logic.

Parameters:
- MOVE_TICKS, default MOVE_TAKI_NIE_MACQUEEN (250_000): clock cycles per 1-pixel climb/walk step.
- JUMP_TICKS, default JUMP_TAKI_W_MIARE (1_400_000): clock cycles per 1-pixel jump step.
- THROW_HOLD, default 3: number of MOVE_TICKS periods the throw frame is held.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin intro; sampled only in IDLE.
- restart  in  1  synchronous return to IDLE; highest priority after reset.
- throw_req  in  1  request a barrel throw; sampled only in ACTIVE.
- jump_req  in  1  request a jump; sampled only in ACTIVE.
- xpos  out  12  sprite left x, unsigned.
- ypos  out  12  sprite top y, unsigned.
- frame  out  2  sprite select: 0 idle, 1 climb-alt, 2 walk/jump, 3 throw.
- intro_done  out  1  high while in ACTIVE, THROW, JUMP_UP or JUMP_DOWN.
- barrel_spawn  out  1  one-cycle pulse on throw start.
- busy  out  1  high in every state except IDLE and ACTIVE.

Behaviour:
- All outputs are registered.
- Reset (rst_n low, async) sets:
  - state IDLE, tick counter 0;
  - xpos = KONG_ANIMATION_INITIAL_XPOS (484), ypos = KONG_ANIMATION_INITIAL_YPOS (672);
  - frame 0, intro_done 0, barrel_spawn 0, busy 0.
- Tick counter:
  - Cleared to 0 on every state entry.
  - Counts 0..P-1, where P = MOVE_TICKS in CLIMB/WALK/THROW and JUMP_TICKS in JUMP_UP/JUMP_DOWN.
  - A "step" occurs in the cycle the counter equals P-1; the counter then wraps to 0.
- IDLE:
  - Outputs hold their initial values.
  - start=1 -> CLIMB next cycle.
- CLIMB:
  - Each step: ypos -= 1, and frame toggles 0/1.
  - The step that makes ypos == KONG_PLATFORM_YPOS (175) also moves the state to WALK.
  - Total 497 steps.
- WALK:
  - frame 2.
  - Each step: xpos -= 1.
  - The step that makes xpos == KONG_PLATFORM_XPOS (128) moves the state to ACTIVE, and intro_done rises in that same cycle.
  - Total 356 steps.
- ACTIVE:
  - frame 0, xpos=128, ypos=175.
  - throw_req -> THROW; else jump_req -> JUMP_UP. Throw wins when both are high.
- THROW:
  - barrel_spawn = 1 for exactly the first cycle of THROW.
  - frame 3.
  - After THROW_HOLD steps -> ACTIVE.
- JUMP_UP:
  - frame 2.
  - Each step: ypos -= 1.
  - After KONG_JUMP_HEIGHT (58) steps (ypos = 117) -> JUMP_DOWN.
- JUMP_DOWN:
  - Each step: ypos += 1.
  - When ypos == 175 -> ACTIVE.
- Requests outside their sampling state are ignored, not queued: start outside IDLE, and throw_req/jump_req outside ACTIVE.
- restart=1 in any state:
  - Next cycle: state IDLE with all reset values.
  - Any pending barrel_spawn is suppressed.
- Arithmetic: 12-bit unsigned; no wrap is possible given the constant ranges. The bench asserts no underflow.
- Step periods of 1 are legal (a step occurs every cycle).

Decomposition:
- Add to kong_pkg:
  - enum kong_state_t {IDLE, CLIMB, WALK, ACTIVE, THROW, JUMP_UP, JUMP_DOWN};
  - POS_W = 12;
  - KONG_THROW_HOLD = 3;
  - frame codes KONG_FRM_IDLE/ALT/WALK/THROW.
- One sub-module, kong_tick:
  - Loadable prescaler with inputs clr and period.
  - Output step pulse.
  - Shared by all moving states.

Test Plan:
(All scenarios use MOVE_TICKS=4, JUMP_TICKS=8, THROW_HOLD=3.)
1. Reset mid-operation (rst_n low during CLIMB) -> same cycle xpos=484, ypos=672, frame 0, busy 0; stays in IDLE until start.
2. start pulse in IDLE:
   - ypos hits 175 exactly 497*4=1988 cycles after CLIMB entry;
   - xpos hits 128 after another 356*4=1424 cycles;
   - intro_done rises in that cycle;
   - throw_req/jump_req held high during the intro have no effect.
3. throw_req in ACTIVE:
   - barrel_spawn high exactly 1 cycle;
   - frame=3 for 12 cycles, then frame 0 in ACTIVE;
   - a second throw_req during THROW spawns nothing.
4. jump_req in ACTIVE:
   - ypos reaches 117 after 58*8=464 cycles, returns to 175 after a further 464 cycles;
   - xpos stays 128; intro_done stays 1.
5. throw_req and jump_req asserted in the same cycle -> THROW taken (barrel_spawn pulse), no jump afterwards unless re-requested.
6. restart mid-WALK and mid-JUMP_UP -> next cycle IDLE, xpos=484, ypos=672, intro_done 0; a new start replays the full intro.

Source files
------------

// File: rtl/kong_pkg.sv
// Shared types and constants for the Kong sprite sequencer.
package kong_pkg;

    localparam int POS_W  = 12;
    localparam int TICK_W = 24;

    localparam int MOVE_TAKI_NIE_MACQUEEN = 250_000;
    localparam int JUMP_TAKI_W_MIARE      = 1_400_000;
    localparam int KONG_THROW_HOLD        = 3;

    localparam logic [POS_W-1:0] KONG_ANIMATION_INITIAL_XPOS = 12'd484;
    localparam logic [POS_W-1:0] KONG_ANIMATION_INITIAL_YPOS = 12'd672;
    localparam logic [POS_W-1:0] KONG_PLATFORM_XPOS          = 12'd128;
    localparam logic [POS_W-1:0] KONG_PLATFORM_YPOS          = 12'd175;
    localparam logic [POS_W-1:0] KONG_JUMP_HEIGHT            = 12'd58;
    localparam logic [POS_W-1:0] KONG_JUMP_TOP_YPOS          = KONG_PLATFORM_YPOS - KONG_JUMP_HEIGHT;

    localparam logic [1:0] KONG_FRM_IDLE  = 2'd0;
    localparam logic [1:0] KONG_FRM_ALT   = 2'd1;
    localparam logic [1:0] KONG_FRM_WALK  = 2'd2;
    localparam logic [1:0] KONG_FRM_THROW = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        CLIMB,
        WALK,
        ACTIVE,
        THROW,
        JUMP_UP,
        JUMP_DOWN
    } kong_state_t;

endpackage

// File: rtl/kong_tick.sv
// Loadable step prescaler: step is high in the cycle the count reaches period-1.
module kong_tick
    import kong_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [TICK_W-1:0] period,
    output logic              step
);

    logic [TICK_W-1:0] cnt;

    assign step = (cnt == period - TICK_W'(1));

    // Count up, wrapping on a step; clr restarts the period from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || step) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TICK_W'(1);
        end
    end

endmodule

// File: rtl/kong_ctrl.sv
// Kong intro animation and platform action sequencer.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | at the initial animation point, waiting for start
// CLIMB     | climbing up one pixel per step, frame toggles 0/1
// WALK      | walking left onto the platform
// ACTIVE    | standing on the platform, serving requests
// THROW     | holding the throw frame after spawning a barrel
// JUMP_UP   | rising one pixel per jump step
// JUMP_DOWN | falling back to platform height
module kong_ctrl
    import kong_pkg::*;
#(
    parameter int MOVE_TICKS = MOVE_TAKI_NIE_MACQUEEN,
    parameter int JUMP_TICKS = JUMP_TAKI_W_MIARE,
    parameter int THROW_HOLD = KONG_THROW_HOLD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             restart,
    input  logic             throw_req,
    input  logic             jump_req,
    output logic [POS_W-1:0] xpos,
    output logic [POS_W-1:0] ypos,
    output logic [1:0]       frame,
    output logic             intro_done,
    output logic             barrel_spawn,
    output logic             busy
);

    localparam int HOLD_W = (THROW_HOLD > 1) ? $clog2(THROW_HOLD) : 1;

    kong_state_t       state, state_nxt;
    logic [POS_W-1:0]  xpos_nxt, ypos_nxt;
    logic [1:0]        frame_nxt;
    logic              intro_nxt, spawn_nxt, busy_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              tick_clr, step;
    logic [TICK_W-1:0] tick_period;

    kong_tick u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tick_clr),
        .period (tick_period),
        .step   (step)
    );

    // State and every output are registered; next values come from the comb block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            xpos         <= KONG_ANIMATION_INITIAL_XPOS;
            ypos         <= KONG_ANIMATION_INITIAL_YPOS;
            frame        <= KONG_FRM_IDLE;
            intro_done   <= 1'b0;
            barrel_spawn <= 1'b0;
            busy         <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            xpos         <= xpos_nxt;
            ypos         <= ypos_nxt;
            frame        <= frame_nxt;
            intro_done   <= intro_nxt;
            barrel_spawn <= spawn_nxt;
            busy         <= busy_nxt;
            hold_cnt     <= hold_nxt;
        end
    end

    // Next state, next outputs and prescaler control.
    always_comb begin
        state_nxt = state;
        xpos_nxt  = xpos;
        ypos_nxt  = ypos;
        frame_nxt = frame;
        hold_nxt  = hold_cnt;
        spawn_nxt = 1'b0;

        if (restart) begin
            state_nxt = IDLE;
            xpos_nxt  = KONG_ANIMATION_INITIAL_XPOS;
            ypos_nxt  = KONG_ANIMATION_INITIAL_YPOS;
            frame_nxt = KONG_FRM_IDLE;
            hold_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state_nxt = CLIMB;
                end
                CLIMB: begin
                    if (step) begin
                        ypos_nxt  = ypos - POS_W'(1);
                        frame_nxt = (frame == KONG_FRM_ALT) ? KONG_FRM_IDLE : KONG_FRM_ALT;
                        if (ypos_nxt == KONG_PLATFORM_YPOS) begin
                            state_nxt = WALK;
                            frame_nxt = KONG_FRM_WALK;
                        end
                    end
                end
                WALK: begin
                    if (step) begin
                        xpos_nxt = xpos - POS_W'(1);
                        if (xpos_nxt == KONG_PLATFORM_XPOS) begin
                            state_nxt = ACTIVE;
                            frame_nxt = KONG_FRM_IDLE;
                        end
                    end
                end
                ACTIVE: begin
                    if (throw_req) begin
                        state_nxt = THROW;
                        frame_nxt = KONG_FRM_THROW;
                        spawn_nxt = 1'b1;
                        hold_nxt  = '0;
                    end else if (jump_req) begin
                        state_nxt = JUMP_UP;
                        frame_nxt = KONG_FRM_WALK;
                    end
                end
                THROW: begin
                    if (step) begin
                        if (hold_cnt == HOLD_W'(THROW_HOLD - 1)) begin
                            state_nxt = ACTIVE;
                            frame_nxt = KONG_FRM_IDLE;
                        end else begin
                            hold_nxt = hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                JUMP_UP: begin
                    if (step) begin
                        ypos_nxt = ypos - POS_W'(1);
                        if (ypos_nxt == KONG_JUMP_TOP_YPOS) state_nxt = JUMP_DOWN;
                    end
                end
                JUMP_DOWN: begin
                    if (step) begin
                        ypos_nxt = ypos + POS_W'(1);
                        if (ypos_nxt == KONG_PLATFORM_YPOS) begin
                            state_nxt = ACTIVE;
                            frame_nxt = KONG_FRM_IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        intro_nxt = (state_nxt inside {ACTIVE, THROW, JUMP_UP, JUMP_DOWN});
        busy_nxt  = !(state_nxt inside {IDLE, ACTIVE});

        // The prescaler restarts on any state change so each state begins a full period.
        tick_clr    = (state_nxt != state) || (state == IDLE) || (state == ACTIVE);
        tick_period = (state == JUMP_UP || state == JUMP_DOWN) ? TICK_W'(JUMP_TICKS)
                                                              : TICK_W'(MOVE_TICKS);
    end

endmodule

// File: tb/tb_kong_ctrl.sv
// Self-checking bench for kong_ctrl with a time-in-phase reference model.
module tb_kong_ctrl;

    localparam int MT = 4;
    localparam int JT = 8;
    localparam int TH = 3;

    localparam int X0 = 484, Y0 = 672, XP = 128, YP = 175, JH = 58;
    localparam int CLIMB_CYC = (Y0 - YP) * MT;
    localparam int WALK_CYC  = (X0 - XP) * MT;
    localparam int THROW_CYC = TH * MT;
    localparam int JUMP_CYC  = JH * JT;

    localparam int P_IDLE = 0, P_CLIMB = 1, P_WALK = 2, P_ACTIVE = 3,
                   P_THROW = 4, P_UP = 5, P_DOWN = 6;

    logic        clk = 1'b0;
    logic        rst_n, start, restart, throw_req, jump_req;
    logic [11:0] xpos, ypos;
    logic [1:0]  frame;
    logic        intro_done, barrel_spawn, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int m_phase  = P_IDLE;
    int m_t      = 0;
    int m_nxt;
    int m_spawns = 0;
    int o_spawns = 0;

    kong_ctrl #(.MOVE_TICKS(MT), .JUMP_TICKS(JT), .THROW_HOLD(TH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .restart      (restart),
        .throw_req    (throw_req),
        .jump_req     (jump_req),
        .xpos         (xpos),
        .ypos         (ypos),
        .frame        (frame),
        .intro_done   (intro_done),
        .barrel_spawn (barrel_spawn),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs from the phase and the cycles spent in it.
    function automatic logic [28:0] exp_vec(input int ph, input int t);
        logic [11:0] x, y;
        logic [1:0]  f;
        logic        it, sp, bz;
        x = 12'(X0); y = 12'(Y0); f = 2'd0; it = 1'b0; sp = 1'b0; bz = 1'b0;
        case (ph)
            P_CLIMB: begin y = 12'(Y0 - t / MT); f = 2'((t / MT) % 2); bz = 1'b1; end
            P_WALK:  begin x = 12'(X0 - t / MT); y = 12'(YP); f = 2'd2; bz = 1'b1; end
            P_ACTIVE: begin x = 12'(XP); y = 12'(YP); it = 1'b1; end
            P_THROW: begin
                x = 12'(XP); y = 12'(YP); f = 2'd3; it = 1'b1; bz = 1'b1; sp = (t == 0);
            end
            P_UP:   begin x = 12'(XP); y = 12'(YP - t / JT); f = 2'd2; it = 1'b1; bz = 1'b1; end
            P_DOWN: begin x = 12'(XP); y = 12'(YP - JH + t / JT); f = 2'd2; it = 1'b1; bz = 1'b1; end
            default: ;
        endcase
        return {x, y, f, it, sp, bz};
    endfunction

    // Reference model: phase plus elapsed cycles, advanced on each clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = P_IDLE;
            m_t     = 0;
        end else begin
            m_nxt = m_phase;
            if (restart) m_nxt = P_IDLE;
            else begin
                case (m_phase)
                    P_IDLE:   if (start) m_nxt = P_CLIMB;
                    P_CLIMB:  if (m_t == CLIMB_CYC - 1) m_nxt = P_WALK;
                    P_WALK:   if (m_t == WALK_CYC - 1) m_nxt = P_ACTIVE;
                    P_ACTIVE: if (throw_req) m_nxt = P_THROW; else if (jump_req) m_nxt = P_UP;
                    P_THROW:  if (m_t == THROW_CYC - 1) m_nxt = P_ACTIVE;
                    P_UP:     if (m_t == JUMP_CYC - 1) m_nxt = P_DOWN;
                    P_DOWN:   if (m_t == JUMP_CYC - 1) m_nxt = P_ACTIVE;
                    default:  m_nxt = P_IDLE;
                endcase
            end
            if (m_nxt != m_phase || restart) m_t = 0;
            else m_t = m_t + 1;
            m_phase = m_nxt;
        end
    end

    // Every cycle: outputs against the model, and positions never wrap.
    always @(negedge clk) begin
        logic [28:0] e;
        e = exp_vec(m_phase, m_t);
        check_val("cyc", 32'({xpos, ypos, frame, intro_done, barrel_spawn, busy}), 32'(e));
        check_val("range", 32'(ypos <= 12'(Y0) && xpos <= 12'(X0)), 32'd1);
        if (e[1]) m_spawns++;
        if (barrel_spawn) o_spawns++;
    end

    function automatic bit dut_cond(input int c);
        case (c)
            0: return ypos == 12'(YP);
            1: return xpos == 12'(XP);
            2: return ypos == 12'(YP - JH);
            3: return m_phase == P_WALK;
            default: return 1'b1;
        endcase
    endfunction

    // Wait for a condition; requests held high whenever they must be ignored.
    task automatic wait_dut(input int c, input int budget, input bit noise, output int n);
        n = 0;
        while (!dut_cond(c) && n < budget) begin
            throw_req = noise && (m_phase != P_ACTIVE);
            jump_req  = noise && (m_phase != P_ACTIVE);
            @(negedge clk);
            n++;
        end
        throw_req = 1'b0;
        jump_req  = 1'b0;
    endtask

    task automatic wait_active(input int budget);
        int n;
        n = 0;
        while (m_phase != P_ACTIVE && n < budget) begin
            throw_req = 1'($urandom) && (m_phase != P_ACTIVE);
            jump_req  = 1'($urandom) && (m_phase != P_ACTIVE);
            @(negedge clk);
            n++;
        end
        throw_req = 1'b0;
        jump_req  = 1'b0;
        check_val("settle", 32'({busy, intro_done}), 32'b01);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_restart(input string tag);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check_val({tag, "_pos"}, 32'({xpos, ypos}), 32'({12'(X0), 12'(Y0)}));
        check_val({tag, "_flags"}, 32'({frame, intro_done, barrel_spawn, busy}), 32'd0);
    endtask

    task automatic full_intro(input string tag);
        int n;
        pulse_start();
        wait_dut(0, CLIMB_CYC + 50, 1'b1, n);
        check_val({tag, "_climb_len"}, 32'(n), 32'(CLIMB_CYC));
        check_val({tag, "_walk_frame"}, 32'(frame), 32'd2);
        wait_dut(1, WALK_CYC + 50, 1'b1, n);
        check_val({tag, "_walk_len"}, 32'(n), 32'(WALK_CYC));
        check_val({tag, "_intro_done"}, 32'(intro_done), 32'd1);
    endtask

    initial begin
        int n, ns, nf, nb, op;
        rst_n = 1'b0; start = 1'b0; restart = 1'b0; throw_req = 1'b0; jump_req = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_pos", 32'({xpos, ypos}), 32'({12'(X0), 12'(Y0)}));
        check_val("rst_flags", 32'({frame, intro_done, barrel_spawn, busy}), 32'd0);
        rst_n = 1'b1;

        repeat ($urandom_range(2, 10)) begin
            throw_req = 1'($urandom);
            jump_req  = 1'($urandom);
            @(negedge clk);
        end
        throw_req = 1'b0; jump_req = 1'b0;
        check_val("idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset partway up the climb.
        pulse_start();
        repeat ($urandom_range(20, 200)) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_pos", 32'({xpos, ypos}), 32'({12'(X0), 12'(Y0)}));
        check_val("async_flags", 32'({frame, intro_done, busy}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat ($urandom_range(3, 12)) @(negedge clk);
        check_val("post_rst_idle", 32'({busy, ypos}), 32'({1'b0, 12'(Y0)}));

        full_intro("intro1");

        // Single throw, with a second request during the hold.
        throw_req = 1'b1;
        @(negedge clk);
        throw_req = 1'b0;
        ns = 0; nf = 0;
        for (int i = 0; i < 24; i++) begin
            ns += int'(barrel_spawn);
            nf += int'(frame == 2'd3);
            throw_req = (i == 5);
            @(negedge clk);
        end
        check_val("throw_spawns", 32'(ns), 32'd1);
        check_val("throw_frames", 32'(nf), 32'(THROW_CYC));
        check_val("throw_after", 32'({frame, busy}), 32'd0);

        // Jump up and back down.
        jump_req = 1'b1;
        @(negedge clk);
        jump_req = 1'b0;
        wait_dut(2, JUMP_CYC + 50, 1'b1, n);
        check_val("jump_up_len", 32'(n), 32'(JUMP_CYC));
        check_val("jump_top_x", 32'({xpos, intro_done}), 32'({12'(XP), 1'b1}));
        wait_dut(0, JUMP_CYC + 50, 1'b1, n);
        check_val("jump_down_len", 32'(n), 32'(JUMP_CYC));
        @(negedge clk);
        check_val("jump_done", 32'({busy, frame}), 32'd0);

        // Throw and jump together: throw wins, no jump follows.
        throw_req = 1'b1; jump_req = 1'b1;
        @(negedge clk);
        throw_req = 1'b0; jump_req = 1'b0;
        ns = 0; nf = 0; nb = 0;
        for (int i = 0; i < 40; i++) begin
            ns += int'(barrel_spawn);
            nf += int'(frame == 2'd3);
            nb += int'(busy);
            @(negedge clk);
        end
        check_val("both_spawns", 32'(ns), 32'd1);
        check_val("both_frames", 32'(nf), 32'(THROW_CYC));
        check_val("both_busy", 32'(nb), 32'(THROW_CYC));

        // Random sequence of requests from ACTIVE.
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            op = int'($urandom_range(0, 2));
            throw_req = (op != 1);
            jump_req  = (op != 0);
            @(negedge clk);
            throw_req = 1'b0; jump_req = 1'b0;
            wait_active(2 * JUMP_CYC + 50);
        end

        // Restart mid-walk, then replay the intro.
        pulse_start();
        wait_dut(3, CLIMB_CYC + 50, 1'b0, n);
        repeat ($urandom_range(1, WALK_CYC - 100)) @(negedge clk);
        do_restart("rst_walk");
        repeat ($urandom_range(1, 5)) @(negedge clk);
        full_intro("intro2");

        // Restart mid-jump, then replay the intro.
        jump_req = 1'b1;
        @(negedge clk);
        jump_req = 1'b0;
        repeat ($urandom_range(1, JUMP_CYC - 20)) @(negedge clk);
        do_restart("rst_jump");
        full_intro("intro3");

        check_val("spawn_total", 32'(o_spawns), 32'(m_spawns));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
